// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - receive byte FIFO between UART receiver and APB registers
// First-word-fall-through circular buffer with registered status and sticky overflow.
module uart_rx_fifo_ctrl #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int THRESH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fifo_write_n,
  input  logic [7:0]        wr_data,
  input  logic              read_rx_byte,
  input  logic              clear_overflow,
  output logic [7:0]        rx_dout,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_level,
  output logic              rx_thresh,
  output logic              overflow
);

  localparam logic [ADDR_W:0] DEPTH_LVL  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] THRESH_LVL = (ADDR_W+1)'(THRESH);

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic              wr_acc;
  logic              rd_acc;
  logic              ovf_set;

  // A write into a full buffer is still taken when a pop frees the head slot this cycle.
  assign rd_acc  = read_rx_byte && !fifo_empty;
  assign wr_acc  = !fifo_write_n && (!fifo_full || read_rx_byte);
  assign ovf_set = !fifo_write_n && fifo_full && !read_rx_byte;

  always_comb begin
    level_nxt = fifo_level;
    if (wr_acc && !rd_acc) begin
      level_nxt = fifo_level + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      level_nxt = fifo_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      rx_thresh  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      // Status flags derive from the next level so they never disagree with fifo_level.
      fifo_level <= level_nxt;
      fifo_empty <= (level_nxt == '0);
      fifo_full  <= (level_nxt == DEPTH_LVL);
      rx_thresh  <= (level_nxt >= THRESH_LVL);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow <= 1'b0;
    end else if (ovf_set) begin
      overflow <= 1'b1;
    end else if (clear_overflow) begin
      overflow <= 1'b0;
    end
  end

  assign rx_dout = fifo_empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - directed self-checking bench for uart_rx_fifo_ctrl
module tb_uart_rx_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fifo_write_n;
  logic [7:0] wr_data;
  logic       read_rx_byte;
  logic       clear_overflow;
  logic [7:0] rx_dout;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_level;
  logic       rx_thresh;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  uart_rx_fifo_ctrl #(.DEPTH(16), .ADDR_W(4), .THRESH(8)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .fifo_write_n   (fifo_write_n),
    .wr_data        (wr_data),
    .read_rx_byte   (read_rx_byte),
    .clear_overflow (clear_overflow),
    .rx_dout        (rx_dout),
    .fifo_empty     (fifo_empty),
    .fifo_full      (fifo_full),
    .fifo_level     (fifo_level),
    .rx_thresh      (rx_thresh),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fifo_write_n = 1'b0;
    wr_data      = d;
    tick();
    fifo_write_n = 1'b1;
  endtask

  task automatic pop();
    read_rx_byte = 1'b1;
    tick();
    read_rx_byte = 1'b0;
  endtask

  task automatic fill_from(input logic [7:0] base);
    for (int i = 0; i < 16; i++) push(base + 8'(i));
  endtask

  initial begin
    reset_n        = 1'b0;
    fifo_write_n   = 1'b1;
    wr_data        = 8'h00;
    read_rx_byte   = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_thresh", rx_thresh, 0);
    chk("rst_dout", rx_dout, 8'h00);

    // single byte round trip
    push(8'hA5);
    chk("a5_empty", fifo_empty, 0);
    chk("a5_level", fifo_level, 1);
    chk("a5_dout", rx_dout, 8'hA5);
    pop();
    chk("a5_pop_empty", fifo_empty, 1);
    chk("a5_pop_level", fifo_level, 0);

    // fill to full, watch thresh and full flags
    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      chk("fill_level", fifo_level, i + 1);
      chk("fill_thresh", rx_thresh, (i + 1 >= 8) ? 1 : 0);
      chk("fill_full", fifo_full, (i + 1 == 16) ? 1 : 0);
    end
    push(8'hFF);
    chk("ovf_set", overflow, 1);
    chk("ovf_level", fifo_level, 16);
    chk("ovf_full", fifo_full, 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", rx_dout, i);
      pop();
    end
    chk("drain_empty", fifo_empty, 1);
    chk("drain_thresh", rx_thresh, 0);
    chk("drain_ovf_sticky", overflow, 1);
    pop();
    chk("empty_pop_level", fifo_level, 0);
    chk("empty_pop_empty", fifo_empty, 1);

    // pointer wrap plus overflow clear priority
    fill_from(8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_pop_data", rx_dout, i);
      pop();
    end
    chk("wrap_level12", fifo_level, 12);
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    chk("wrap_full", fifo_full, 1);
    fifo_write_n   = 1'b0;
    wr_data        = 8'hEE;
    clear_overflow = 1'b1;
    tick();
    fifo_write_n   = 1'b1;
    clear_overflow = 1'b0;
    chk("clr_vs_set", overflow, 1);
    chk("clr_vs_set_level", fifo_level, 16);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    chk("clr_alone", overflow, 0);
    for (int i = 0; i < 12; i++) begin
      chk("wrap_drain_a", rx_dout, 4 + i);
      pop();
    end
    for (int i = 0; i < 4; i++) begin
      chk("wrap_drain_b", rx_dout, 8'h10 + i);
      pop();
    end
    chk("wrap_empty", fifo_empty, 1);

    // simultaneous read and write at full
    fill_from(8'h20);
    fifo_write_n = 1'b0;
    wr_data      = 8'h55;
    read_rx_byte = 1'b1;
    tick();
    fifo_write_n = 1'b1;
    read_rx_byte = 1'b0;
    chk("rw_full_level", fifo_level, 16);
    chk("rw_full_full", fifo_full, 1);
    chk("rw_full_ovf", overflow, 0);
    for (int i = 0; i < 15; i++) begin
      chk("rw_full_data", rx_dout, 8'h21 + i);
      pop();
    end
    chk("rw_full_last", rx_dout, 8'h55);
    pop();
    chk("rw_full_empty", fifo_empty, 1);

    // simultaneous read and write at empty
    fifo_write_n = 1'b0;
    wr_data      = 8'h77;
    read_rx_byte = 1'b1;
    tick();
    fifo_write_n = 1'b1;
    read_rx_byte = 1'b0;
    chk("rw_empty_level", fifo_level, 1);
    chk("rw_empty_dout", rx_dout, 8'h77);
    chk("rw_empty_empty", fifo_empty, 0);
    pop();

    // asynchronous reset mid-stream with overflow set
    fill_from(8'h40);
    push(8'h99);
    for (int i = 0; i < 11; i++) pop();
    chk("pre_rst_level", fifo_level, 5);
    chk("pre_rst_ovf", overflow, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_empty", fifo_empty, 1);
    chk("arst_level", fifo_level, 0);
    chk("arst_ovf", overflow, 0);
    #2;
    reset_n = 1'b1;
    tick();
    push(8'h3C);
    chk("post_rst_level", fifo_level, 1);
    chk("post_rst_dout", rx_dout, 8'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
